// File: rtl/mutex_lock.sv
// mutex_lock: turns the priority mutex's momentary winner into a held single-owner lock
// with bounded hold time and a post-release cooldown. Define MUTEX_LOCK_STATS_EN for grant/expiry counters.
module mutex_lock #(
   parameter int NIn      = 8,
   parameter int NOut     = 3,
   parameter int MaxHold  = 15,
   parameter int Cooldown = 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          reqValid,
   input  logic [NOut:0] reqPin,
   input  logic [NIn:0]  active,
   output logic          locked,
   output logic [NOut:0] owner,
   output logic [NIn:0]  grant,
   output logic          expired
`ifdef MUTEX_LOCK_STATS_EN
   ,
   output logic [15:0]   grants,
   output logic [15:0]   expiries
`endif
);

   localparam int HW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
   localparam int GW = (Cooldown > 0) ? $clog2(Cooldown + 1) : 1;
   localparam int PW = NOut + 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MaxHold);
   localparam logic [GW-1:0] GAP_MAX  = GW'(Cooldown);
   localparam logic [PW-1:0] MAX_PIN  = PW'(NIn);
   localparam logic [NIn:0]  ONE_HOT  = {{NIn{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, HELD, GAP} state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic [GW-1:0] gap_cnt;
   logic          accept;
   logic          owner_gone;
   logic          hold_done;

   // Out-of-range pins are treated as no request at all.
   assign accept     = reqValid && (reqPin <= MAX_PIN);
   assign owner_gone = ~|(active & grant);
   assign hold_done  = (MaxHold != 0) && (hold_cnt == HOLD_MAX);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         locked   <= 1'b0;
         owner    <= '0;
         grant    <= '0;
         expired  <= 1'b0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         expired <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state    <= HELD;
                  locked   <= 1'b1;
                  owner    <= reqPin;
                  grant    <= ONE_HOT << reqPin;
                  hold_cnt <= HW'(1);
               end
            end
            HELD: begin
               // Release outranks expiry, so a same-edge drop never pulses expired.
               if (owner_gone || hold_done) begin
                  locked   <= 1'b0;
                  owner    <= '0;
                  grant    <= '0;
                  hold_cnt <= '0;
                  expired  <= !owner_gone;
                  gap_cnt  <= GW'(1);
                  state    <= (Cooldown == 0) ? IDLE : GAP;
               end else if (MaxHold != 0 && hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            GAP: begin
               if (gap_cnt == GAP_MAX) begin
                  state   <= IDLE;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MUTEX_LOCK_STATS_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grants   <= '0;
         expiries <= '0;
      end else begin
         if (state == IDLE && accept)
            grants <= sat_inc16(grants);
         if (state == HELD && !owner_gone && hold_done)
            expiries <= sat_inc16(expiries);
      end
   end
`endif

endmodule

// File: tb/tb_mutex_lock.sv
// Scoreboard bench for mutex_lock: expected output words are queued as stimulus is driven
// and popped after each clock edge for comparison.
module tb_mutex_lock;

   localparam int NIn      = 8;
   localparam int NOut     = 3;
   localparam int MaxHold  = 15;
   localparam int Cooldown = 1;

   logic       clock    = 1'b0;
   logic       reset    = 1'b0;
   logic       reqValid = 1'b0;
   logic [3:0] reqPin   = '0;
   logic [8:0] active   = '0;
   logic       locked;
   logic [3:0] owner;
   logic [8:0] grant;
   logic       expired;
`ifdef MUTEX_LOCK_STATS_EN
   logic [15:0] grants;
   logic [15:0] expiries;
   logic [31:0] sq[$];
`endif

   int checks = 0;
   int passes = 0;
   logic [14:0] sb[$];

   always #5 clock = ~clock;

   mutex_lock #(
      .NIn(NIn), .NOut(NOut), .MaxHold(MaxHold), .Cooldown(Cooldown)
   ) dut (
      .clock(clock),
      .reset(reset),
      .reqValid(reqValid),
      .reqPin(reqPin),
      .active(active),
      .locked(locked),
      .owner(owner),
      .grant(grant),
      .expired(expired)
`ifdef MUTEX_LOCK_STATS_EN
      ,
      .grants(grants),
      .expiries(expiries)
`endif
   );

   function automatic logic [14:0] mk(input logic lk, input logic [3:0] own,
                                      input logic [8:0] gr, input logic ex);
      return {lk, own, gr, ex};
   endfunction

   task automatic drive(input logic v, input logic [3:0] p, input logic [8:0] a);
      reqValid = v;
      reqPin   = p;
      active   = a;
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      logic [14:0] e;
      drive(1'b0, 4'd0, 9'h000);
      for (int i = 0; i < 2; i++) begin
         sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL reset cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
      reset = 1'b1;
   endtask

   task automatic test_release;
      logic [14:0] e;
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(1'b1, 4'd5, 9'h020);
         else       drive(1'b0, 4'd0, 9'h000);
         sb.push_back(i < 4 ? mk(1'b1, 4'd5, 9'h020, 1'b0) : mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL release cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
   endtask

   task automatic test_expiry;
      logic [14:0] e;
      for (int i = 0; i < 20; i++) begin
         if (i < 18) drive(1'b1, 4'd2, 9'h004);
         else        drive(1'b0, 4'd0, 9'h000);
         if (i < 15 || i == 17) sb.push_back(mk(1'b1, 4'd2, 9'h004, 1'b0));
         else if (i == 15)      sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b1));
         else                   sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL expiry cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
   endtask

   task automatic test_no_queue;
      logic [14:0] e;
      for (int i = 0; i < 9; i++) begin
         if (i == 0)      drive(1'b1, 4'd3, 9'h008);
         else if (i < 4)  drive(1'b1, 4'd7, 9'h088);
         else if (i < 7)  drive(1'b1, 4'd7, 9'h080);
         else             drive(1'b0, 4'd0, 9'h000);
         if (i < 4)       sb.push_back(mk(1'b1, 4'd3, 9'h008, 1'b0));
         else if (i == 6) sb.push_back(mk(1'b1, 4'd7, 9'h080, 1'b0));
         else             sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL no_queue cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
   endtask

   task automatic test_same_edge;
      logic [14:0] e;
      for (int i = 0; i < 17; i++) begin
         if (i < 15) drive(1'b1, 4'd6, 9'h040);
         else        drive(1'b0, 4'd0, 9'h000);
         sb.push_back(i < 15 ? mk(1'b1, 4'd6, 9'h040, 1'b0) : mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL same_edge cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
   endtask

   task automatic test_bad_pin;
      logic [14:0] e;
      for (int i = 0; i < 6; i++) begin
         if (i < 2)       drive(1'b1, 4'd12, 9'h1FF);
         else if (i == 2) drive(1'b1, 4'd9, 9'h1FF);
         else if (i == 3) drive(1'b1, 4'd8, 9'h100);
         else             drive(1'b0, 4'd0, 9'h000);
         sb.push_back(i == 3 ? mk(1'b1, 4'd8, 9'h100, 1'b0) : mk(1'b0, 4'd0, 9'h000, 1'b0));
         tick();
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL bad_pin cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
      end
   endtask

   task automatic test_reset_mid_hold;
      logic [14:0] e;
      for (int i = 0; i < 8; i++) begin
         if (i < 6) drive(1'b1, 4'd1, 9'h002);
         else       drive(1'b0, 4'd0, 9'h000);
         if (i == 3) begin
            #2 reset = 1'b0;
            sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
            #1;
         end else begin
            if (i == 4) sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
            else if (i < 6) sb.push_back(mk(1'b1, 4'd1, 9'h002, 1'b0));
            else sb.push_back(mk(1'b0, 4'd0, 9'h000, 1'b0));
            tick();
         end
         e = sb.pop_front();
         checks++;
         if ({locked, owner, grant, expired} !== e)
            $display("FAIL reset_mid_hold cyc%0d: got lk=%b own=%0d gr=%h ex=%b want lk=%b own=%0d gr=%h ex=%b",
                     i, locked, owner, grant, expired, e[14], e[13:10], e[9:1], e[0]);
         else passes++;
         if (i == 4) reset = 1'b1;
      end
   endtask

`ifdef MUTEX_LOCK_STATS_EN
   task automatic test_stats;
      logic [31:0] e;
      for (int k = 0; k < 3; k++) begin
         if (k == 1) begin
            for (int g = 0; g < 2; g++) begin
               drive(1'b1, 4'(g), 9'(1 << g));
               tick();
               tick();
               drive(1'b0, 4'd0, 9'h000);
               tick();
               tick();
            end
            drive(1'b1, 4'd2, 9'h004);
            repeat (16) tick();
            drive(1'b0, 4'd0, 9'h000);
            tick();
            tick();
            sq.push_back({16'd3, 16'd1});
         end else begin
            reset = 1'b0;
            sq.push_back(32'd0);
            #1;
         end
         e = sq.pop_front();
         checks++;
         if ({grants, expiries} !== e)
            $display("FAIL stats step%0d: got grants=%0d expiries=%0d want grants=%0d expiries=%0d",
                     k, grants, expiries, e[31:16], e[15:0]);
         else passes++;
         reset = 1'b1;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_release();
      test_expiry();
      test_no_queue();
      test_same_edge();
      test_bad_pin();
      test_reset_mid_hold();
`ifdef MUTEX_LOCK_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
